// File: rtl/inst_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_buffer
// Purpose  : Dual-issue fetch stage. Latches the fetch PC, issues one 64-bit
//            read at a time on an SRAM-like instruction port, and queues the
//            returned instructions with their PCs in a FIFO. Up to two
//            instructions per cycle are presented to decode.
// Ports    : clk, rst (async, active-low)
//            pc_address           - fetch PC from the PC stage
//            flush                - branch/exception redirect
//            inst_req/inst_addr   - read request, 8-byte aligned address
//            inst_addr_ok         - address accepted
//            inst_data_ok/rdata   - read data return
//            inst_ok_1/inst_ok_2  - PC advance pulses (+4 / +8)
//            out_valid/inst/pc_1  - FIFO head entry
//            out_valid/inst/pc_2  - FIFO head+1 entry
//            issue_1/issue_2      - decode consumes head / head+1
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_address,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [63:0] inst_rdata,
  output logic        inst_ok_1,
  output logic        inst_ok_2,
  output logic        out_valid_1,
  output logic [31:0] out_inst_1,
  output logic [31:0] out_pc_1,
  output logic        out_valid_2,
  output logic [31:0] out_inst_2,
  output logic [31:0] out_pc_2,
  input  logic        issue_1,
  input  logic        issue_2
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_ADDR = 2'd1;
  localparam logic [1:0] S_WAIT_DATA = 2'd2;
  localparam logic [1:0] S_DISCARD   = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [31:0]   pc_q;
  logic          squash;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic [AW:0]   count;
  logic [AW:0]   free_slots;
  logic [AW:0]   push_n;
  logic [AW:0]   pop_n;

  logic          start_fetch;
  logic          push_ok;
  logic          aligned;
  logic          pop_1;
  logic          pop_2;

  // Free-slot check uses the count before this cycle's pops, so two slots are
  // always guaranteed for the single outstanding request.
  assign free_slots  = DEPTH_C - count;
  assign start_fetch = (state == S_IDLE) && !flush && (free_slots >= TWO_C);
  assign push_ok     = (state == S_WAIT_DATA) && inst_data_ok && !flush;
  assign aligned     = ~pc_q[2];

  assign inst_req  = (state == S_WAIT_ADDR);
  assign inst_addr = inst_req ? {pc_q[31:3], 3'b000} : 32'd0;
  assign inst_ok_1 = push_ok;
  assign inst_ok_2 = push_ok & aligned;

  assign out_valid_1 = (count != '0);
  assign out_valid_2 = (count >= TWO_C);
  assign head_p1     = head + AW'(1);
  assign tail_p1     = tail + AW'(1);

  // Outputs are forced to zero when their entry is empty so the unreset
  // storage never leaks out.
  assign out_inst_1 = out_valid_1 ? inst_mem[head]    : 32'd0;
  assign out_pc_1   = out_valid_1 ? pc_mem[head]      : 32'd0;
  assign out_inst_2 = out_valid_2 ? inst_mem[head_p1] : 32'd0;
  assign out_pc_2   = out_valid_2 ? pc_mem[head_p1]   : 32'd0;

  // issue_2 only counts alongside issue_1 with a valid second entry.
  assign pop_1  = issue_1 & out_valid_1;
  assign pop_2  = pop_1 & issue_2 & out_valid_2;
  assign pop_n  = (AW+1)'(pop_1) + (AW+1)'(pop_2);
  assign push_n = push_ok ? (aligned ? TWO_C : (AW+1)'(1)) : '0;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (start_fetch) state_next = S_WAIT_ADDR;
      // A flush never withdraws a pending request; the reply is dropped.
      S_WAIT_ADDR: if (inst_addr_ok) state_next = (flush || squash) ? S_DISCARD : S_WAIT_DATA;
      S_WAIT_DATA: begin
        if (inst_data_ok)  state_next = S_IDLE;
        else if (flush)    state_next = S_DISCARD;
      end
      S_DISCARD:   if (inst_data_ok) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      pc_q   <= 32'd0;
      squash <= 1'b0;
    end else begin
      state <= state_next;
      if (start_fetch) pc_q <= pc_address;
      if (state == S_WAIT_ADDR) begin
        if (inst_addr_ok) squash <= 1'b0;
        else if (flush)   squash <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_n);
      tail  <= tail + AW'(push_n);
      count <= count + push_n - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      if (aligned) begin
        pc_mem[tail]      <= pc_q;
        inst_mem[tail]    <= inst_rdata[31:0];
        pc_mem[tail_p1]   <= pc_q + 32'd4;
        inst_mem[tail_p1] <= inst_rdata[63:32];
      end else begin
        pc_mem[tail]      <= pc_q;
        inst_mem[tail]    <= inst_rdata[63:32];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_buffer.md
Name: inst_fetch_buffer

Overview:
- Fetch stage directly downstream of the PC register in the dual-issue pipeline.
- Takes the current fetch address, issues 64-bit reads on the SRAM-like instruction port, and queues the returned instructions with their PCs in a FIFO.
- Presents up to two instructions per cycle to decode.
- Returns inst_ok_1/inst_ok_2 to the PC stage so the PC advances by 4 or 8; squashes in-flight work on branch/exception flush.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=4); each entry holds {pc[31:0], inst[31:0]}

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
pc_address  input  32  current fetch PC from PC stage
flush  input  1  branch or exception redirect this cycle
inst_req  output  1  instruction port request
inst_addr  output  32  request address, {pc[31:3],3'b000}
inst_addr_ok  input  1  address accepted
inst_data_ok  input  1  read data valid
inst_rdata  input  64  [31:0] at addr, [63:32] at addr+4
inst_ok_1  output  1  one instruction accepted this cycle
inst_ok_2  output  1  second instruction accepted this cycle
out_valid_1  output  1  FIFO head valid
out_inst_1  output  32  head instruction
out_pc_1  output  32  head PC
out_valid_2  output  1  head+1 valid
out_inst_2  output  32  head+1 instruction
out_pc_2  output  32  head+1 PC
issue_1  input  1  decode consumes head
issue_2  input  1  decode consumes head+1; honoured only with issue_1 and out_valid_2

Behaviour:
- Reset (rst low, async):
  - State IDLE; FIFO empty, pointers 0, count 0; latched addr/pc 0.
  - All outputs 0.
- FSM states:
  - IDLE: if !flush and free slots (DEPTH-count, before this cycle's pops) >= 2, latch pc_address, go WAIT_ADDR.
  - WAIT_ADDR: inst_req=1, inst_addr={latched_pc[31:3],3'b0}, held stable until inst_addr_ok.
    - On inst_addr_ok: go WAIT_DATA, or DISCARD if flush in the same cycle.
    - flush without inst_addr_ok: the request is NOT withdrawn; set a squash flag so the eventual addr_ok goes to DISCARD.
  - WAIT_DATA: on inst_data_ok without flush, push and go IDLE.
    - flush with no data_ok: go DISCARD.
    - flush with data_ok in the same cycle: drop data, no inst_ok, go IDLE.
  - DISCARD: on inst_data_ok, drop data, go IDLE; no pulses.
- Push rules:
  - latched_pc[2]==0: push rdata[31:0] @pc, then rdata[63:32] @pc+4; inst_ok_1=inst_ok_2=1.
  - latched_pc[2]==1: push rdata[63:32] @pc only; inst_ok_1=1, inst_ok_2=0.
  - inst_ok_* are single-cycle combinational pulses in the data_ok cycle; 0 otherwise.
  - One outstanding request maximum, so the PC has settled before the next IDLE latch.
- Pop rules:
  - out_valid_1 = count>=1; out_valid_2 = count>=2; outputs read combinationally from the head and head+1 entries.
  - Pop count = issue_1 + (issue_1 & issue_2 & out_valid_2); issue with out_valid low is ignored.
- Count update:
  - count_next = count + pushed - popped in the same cycle.
  - Pointers wrap modulo DEPTH.
  - Overflow is impossible by the >=2 free-slot rule.
- flush:
  - Clears the FIFO (pointers and count to 0) next edge, overriding pushes and pops.
  - out_valid_* low the cycle after.
  - flush has no effect on inst_req already asserted.
- Latency: PC latched -> inst_req next cycle; instructions visible at out_* the cycle after inst_data_ok.

Test Plan:
- Aligned fetch: pc=0xbfc00000, addr_ok immediate, data_ok after 2 cycles with rdata={0x2,0x1} -> inst_addr=0xbfc00000; one-cycle inst_ok_1=inst_ok_2=1; next cycle out_1=(0xbfc00000,0x1), out_2=(0xbfc00004,0x2).
- Misaligned: pc=0xbfc00004, rdata={0xAA,0xBB} -> inst_addr=0xbfc00000; only inst_ok_1; single entry (0xbfc00004,0xAA); out_valid_2=0.
- Backpressure: no issues for DEPTH=8 -> after 3 aligned fetches count=6; 4th fetch issued (free=2); after it count=8; no further inst_req until issue_1&issue_2 pops 2.
- Flush in WAIT_DATA: flush asserted while awaiting data_ok -> FIFO empty next cycle; later data_ok produces no push and no inst_ok; the next request uses the new pc_address.
- Flush in WAIT_ADDR with addr_ok delayed 3 cycles -> inst_addr unchanged until addr_ok; the response is discarded.
- Simultaneous push and pop: count=2, issue_1&issue_2, aligned data_ok -> count stays 2 with the new pair at head.
- Async reset mid-WAIT_DATA: rst low -> outputs 0 immediately; the late data_ok after reset release is ignored (IDLE).
